// File: rtl/spi_slave.sv
// spi_slave: mode-0 MSB-first SPI subordinate with oversampled SCK/CS/MOSI and a one-word tx buffer.
// Define SPI_SLAVE_MISO_TRISTATE_EN to release MISO ('z) outside of an active frame.
module spi_slave #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              SCK,
    input  logic              CS,
    input  logic              MOSI,
    output logic              MISO,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              tx_underrun
);
    localparam int CW = $clog2(DATA_W);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic                   sck_hist, cs_hist;
    logic                   sck_s, cs_s, mosi_s;
    logic                   sck_rise, sck_fall, cs_rise, cs_fall;
    logic [DATA_W-1:0]      tx_shift, rx_shift, buf_data, rx_next;
    logic [CW-1:0]          bit_cnt;
    logic                   buf_full, word_done, last_bit, accept;
    logic                   load, shift_tx, sample, abort;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_hist;
    assign sck_fall = ~sck_s & sck_hist;
    assign cs_rise  = cs_s & ~cs_hist;
    assign cs_fall  = ~cs_s & cs_hist;
    assign tx_ready = ~buf_full;
    assign accept   = tx_valid & ~buf_full;
    assign last_bit = bit_cnt == CW'(DATA_W - 1);
    assign rx_next  = {rx_shift[DATA_W-2:0], mosi_s};

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    assign MISO = (state_q == SHIFT) ? tx_shift[DATA_W-1] : 1'bz;
`else
    assign MISO = (state_q == SHIFT) ? tx_shift[DATA_W-1] : 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_hist  <= 1'b0;
            cs_hist   <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            sck_hist  <= sck_s;
            cs_hist   <= cs_s;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // A falling edge right after a completed word starts the next word instead of shifting.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        shift_tx = 1'b0;
        sample   = 1'b0;
        abort    = 1'b0;
        case (state_q)
            IDLE: begin
                load    = cs_fall;
                state_d = cs_fall ? SHIFT : IDLE;
            end
            SHIFT: begin
                abort    = cs_rise;
                state_d  = cs_rise ? IDLE : SHIFT;
                sample   = ~cs_rise & sck_rise;
                load     = ~cs_rise & sck_fall & word_done;
                shift_tx = ~cs_rise & sck_fall & ~word_done;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_shift    <= '0;
            rx_shift    <= '0;
            buf_data    <= '0;
            buf_full    <= 1'b0;
            bit_cnt     <= '0;
            word_done   <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            busy        <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            busy        <= ~cs_s;
            buf_full    <= accept | (buf_full & ~load);
            if (accept) buf_data <= tx_data;
            if (load) begin
                tx_shift    <= buf_full ? buf_data : '0;
                tx_underrun <= ~buf_full;
            end else if (shift_tx) begin
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            end
            if (sample) begin
                rx_shift  <= rx_next;
                bit_cnt   <= last_bit ? '0 : bit_cnt + CW'(1);
                word_done <= last_bit;
                if (last_bit) begin
                    rx_data  <= rx_next;
                    rx_valid <= 1'b1;
                end
            end
            if (load | abort) word_done <= 1'b0;
            if (abort) bit_cnt <= '0;
        end
    end
endmodule
